// File: rtl/dmem_responder_pkg.sv
// Shared load/store funct3 encoding and the data-memory responder state type.
package single_cycle_processor;

    typedef enum logic [2:0] {
        LS_B  = 3'b000,
        LS_H  = 3'b001,
        LS_W  = 3'b010,
        LS_BU = 3'b100,
        LS_HU = 3'b101
    } load_store_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } dmem_state_e;

endpackage

// File: rtl/dmem_responder_lane_align.sv
// Combinational byte-lane steering for dmem_responder: write enables/data, decode flags,
// and sign/zero extension of the read word.
module dmem_lane_align
    import single_cycle_processor::*;
(
    input  logic [2:0]  i_funct3,
    input  logic        i_we,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misalign,
    output logic        o_illegal,
    output logic [31:0] o_rdata
);

    logic [1:0]  w_lane;
    logic [3:0]  w_mask;
    logic [31:0] w_rshift;

    always_comb begin
        w_lane     = i_addr_lo;
        w_mask     = 4'b0000;
        o_misalign = 1'b0;
        o_illegal  = 1'b0;
        case (i_funct3)
            LS_B, LS_BU: w_mask = 4'b0001;
            LS_H, LS_HU: begin
                w_mask     = 4'b0011;
                o_misalign = i_addr_lo[0];
                w_lane     = {i_addr_lo[1], 1'b0};
            end
            LS_W: begin
                w_mask     = 4'b1111;
                o_misalign = |i_addr_lo;
                w_lane     = 2'b00;
            end
            default: o_illegal = 1'b1;
        endcase
        // Unsigned variants exist only for loads
        if (i_we && i_funct3[2])
            o_illegal = 1'b1;
    end

    assign o_be     = i_we ? (w_mask << w_lane) : 4'b0000;
    assign o_wdata  = i_wdata << {w_lane, 3'b000};
    assign w_rshift = i_rword >> {w_lane, 3'b000};

    always_comb begin
        o_rdata = 32'h0;
        case (i_funct3)
            LS_B:    o_rdata = {{24{w_rshift[7]}}, w_rshift[7:0]};
            LS_H:    o_rdata = {{16{w_rshift[15]}}, w_rshift[15:0]};
            LS_W:    o_rdata = w_rshift;
            LS_BU:   o_rdata = {24'h0, w_rshift[7:0]};
            LS_HU:   o_rdata = {16'h0, w_rshift[15:0]};
            default: o_rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Wait-stated data-memory responder with valid/ready request and response channels.
// Define DMEM_MISALIGN_ERR_EN to fault misaligned half/word accesses instead of aligning them.
module dmem_responder
    import single_cycle_processor::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    dmem_state_e r_state, w_next;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [2:0]  r_funct3;
    logic        r_we, r_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_accept, w_oor, w_err, w_misalign, w_illegal;
    logic [AW-1:0] w_idx;
    logic [3:0]  w_be;
    logic [31:0] w_rword, w_wdata_sh, w_rdata_ext;

    assign w_accept = req_valid & req_ready;
    assign w_idx    = r_addr[AW+1:2];
    assign w_oor    = (r_addr[31:2] >= 30'(DEPTH_WORDS));
    assign w_rword  = w_oor ? 32'h0 : r_mem[w_idx];

`ifdef DMEM_MISALIGN_ERR_EN
    assign w_err = w_illegal | w_oor | w_misalign;
`else
    assign w_err = w_illegal | w_oor;
`endif

    dmem_lane_align u_align (
        .i_funct3   (r_funct3),
        .i_we       (r_we),
        .i_addr_lo  (r_addr[1:0]),
        .i_wdata    (r_wdata),
        .i_rword    (w_rword),
        .o_be       (w_be),
        .o_wdata    (w_wdata_sh),
        .o_misalign (w_misalign),
        .o_illegal  (w_illegal),
        .o_rdata    (w_rdata_ext)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = (WAIT_STATES > 0) ? WAIT : ACCESS;
            WAIT:    if (r_cnt == 4'd0) w_next = ACCESS;
            ACCESS:  w_next = RESP;
            RESP:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= 4'd0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept)
                r_cnt <= CNT_LOAD;
            else if (r_state == WAIT)
                r_cnt <= r_cnt - 4'd1;
            if (r_state == ACCESS) begin
                r_rdata <= (w_err || r_we) ? 32'h0 : w_rdata_ext;
                r_err   <= w_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr   <= req_addr;
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_wdata  <= req_wdata;
        end
    end

    // Commit is suppressed while reset is asserted so an abandoned store never lands
    always_ff @(posedge clk) begin
        if (rst_n && r_state == ACCESS && !w_err) begin
            for (int i = 0; i < 4; i++)
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder (DEPTH_WORDS=1024, WAIT_STATES=1).
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int WS    = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every response at the cycle it is handed over
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rdata %h with no request outstanding", rsp_rdata);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.name, "_rdata"}, rsp_rdata, e.rdata);
                chk({e.name, "_err"}, {31'h0, rsp_err}, {31'h0, e.err});
            end
        end
    end

    task automatic xact(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        int t;
        int lat;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 50) begin @(negedge clk); t++; end
        if (!req_ready) begin
            chk({name, "_accept_timeout"}, {31'h0, req_ready}, 32'h1);
            req_valid = 1'b0;
            return;
        end
        q.push_back('{name, exp_rdata, exp_err});
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = 32'hFFFF_FFF0; req_wdata = 32'h0BAD_0BAD; req_funct3 = 3'b111;
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
        chk({name, "_latency"}, 32'(lat), 32'(WS + 2));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
            @(negedge clk);
            chk({name, "_hold_valid"}, {31'h0, rsp_valid}, 32'h1);
            chk({name, "_hold_rdata"}, rsp_rdata, exp_rdata);
            chk({name, "_hold_req_ready"}, {31'h0, req_ready}, 32'h0);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        int t;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", {31'h0, req_ready}, 32'h1);
        chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_rsp_err",   {31'h0, rsp_err}, 32'h0);

        // Word store/load round trip, then sub-word loads of 0xDEADBEEF
        xact("sw10",  1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
        xact("lw10",  1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
        xact("lb13",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FFDE, 1'b0, 0);
        xact("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_00DE, 1'b0, 0);
        xact("lh10",  1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFF_BEEF, 1'b0, 0);
        xact("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000_DEAD, 1'b0, 0);

        // Partial stores
        xact("sb11",  1'b1, 3'b000, 32'h11, 32'h0000_0055, 32'h0, 1'b0, 0);
        xact("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_55EF, 1'b0, 0);
        xact("sh12",  1'b1, 3'b001, 32'h12, 32'h0000_1234, 32'h0, 1'b0, 0);
        xact("lw10c", 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234_55EF, 1'b0, 5);

        // Errors
        xact("f3_011",   1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 0);
        xact("f3_110",   1'b0, 3'b110, 32'h10, 32'h0, 32'h0, 1'b1, 0);
        xact("sbu",      1'b1, 3'b100, 32'h10, 32'hFF, 32'h0, 1'b1, 0);
        xact("lw_oor",   1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1, 0);
        xact("sw_oor",   1'b1, 3'b010, 32'h1010, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);
        xact("lw10_oor", 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234_55EF, 1'b0, 0);
        xact("sw_top",   1'b1, 3'b010, 32'hFFC, 32'hCAFE_F00D, 32'h0, 1'b0, 0);
        xact("lw_top",   1'b0, 3'b010, 32'hFFC, 32'h0, 32'hCAFE_F00D, 1'b0, 0);

        // Misaligned accesses
`ifdef DMEM_MISALIGN_ERR_EN
        xact("lw12",   1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1, 0);
        xact("lh11",   1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1, 0);
        xact("sh13",   1'b1, 3'b001, 32'h13, 32'h0000_ABCD, 32'h0, 1'b1, 0);
        xact("lw10_m", 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234_55EF, 1'b0, 0);
`else
        xact("lw12",   1'b0, 3'b010, 32'h12, 32'h0, 32'h1234_55EF, 1'b0, 0);
        xact("lh11",   1'b0, 3'b001, 32'h11, 32'h0, 32'h0000_55EF, 1'b0, 0);
        xact("sh13",   1'b1, 3'b001, 32'h13, 32'h0000_ABCD, 32'h0, 1'b0, 0);
        xact("lw10_m", 1'b0, 3'b010, 32'h10, 32'h0, 32'hABCD_55EF, 1'b0, 0);
`endif

        // Reset while a store sits in WAIT
        xact("sw20", 1'b1, 3'b010, 32'h20, 32'h1122_3344, 32'h0, 1'b0, 0);
        xact("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 32'h1122_3344, 1'b0, 0);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'hAAAA_AAAA;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 50) begin @(negedge clk); t++; end
        chk("rst_sw_accept", {31'h0, req_ready}, 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_mid_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_mid_rsp_err",   {31'h0, rsp_err}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_req_ready", {31'h0, req_ready}, 32'h1);
        xact("lw20_after_rst", 1'b0, 3'b010, 32'h20, 32'h0, 32'h1122_3344, 1'b0, 0);

        t = 0;
        while (q.size() != 0 && t < 50) begin @(negedge clk); t++; end
        chk("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
